// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS-style fetch path.
// Holds the fetch FSM state encoding, reset PC and bus widths.
package mips_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned DATA_W     = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/pc_reg.sv
// Program counter with a one-deep pending write slot.
// Writes arriving during a fetch are parked until the fetch retires.
module pc_reg
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_pc_wr,
    input  logic [ADDR_W-1:0] i_npc,
    input  logic              i_busy,
    input  logic              i_done,
    output logic [ADDR_W-1:0] o_pc
);

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_pend;
    logic              r_pend_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= RESET_PC[ADDR_W-1:0];
            r_pend     <= '0;
            r_pend_vld <= 1'b0;
        end else if (!i_busy) begin
            if (i_pc_wr)
                r_pc <= i_npc;
        end else if (i_done) begin
            // A strobe on the retiring cycle is the newest value
            r_pend_vld <= 1'b0;
            if (i_pc_wr)
                r_pc <= i_npc;
            else if (r_pend_vld)
                r_pc <= r_pend;
        end else if (i_pc_wr) begin
            r_pend     <= i_npc;
            r_pend_vld <= 1'b1;
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch FSM: IDLE -> REQ -> WAIT with a req/gnt/rvalid bus.
// Owns the instruction register; the PC lives in pc_reg.
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] npc,
    input  logic              pc_wr,
    input  logic              fetch_start,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] ir,
    output logic              ir_valid,
    output logic              busy,
    output logic              misalign
);

    fetch_state_e      r_state;
    logic              r_req;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_ir;
    logic              r_ir_valid;
    logic              r_misalign;

    logic [ADDR_W-1:0] w_pc;
    logic [ADDR_W-1:0] w_faddr;
    logic              w_misal;
    logic              w_busy;
    logic              w_done;

    assign w_faddr = pc_wr ? npc : w_pc;
    assign w_misal = |w_faddr[1:0];
    assign w_busy  = (r_state != S_IDLE);
    assign w_done  = (r_state == S_REQ && imem_gnt && imem_rvalid)
                   || (r_state == S_WAIT && imem_rvalid);

    pc_reg #(
        .RESET_PC (RESET_PC),
        .ADDR_W   (ADDR_W)
    ) u_pc_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_pc_wr (pc_wr),
        .i_npc   (npc),
        .i_busy  (w_busy),
        .i_done  (w_done),
        .o_pc    (w_pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_req      <= 1'b0;
            r_addr     <= '0;
            r_ir       <= '0;
            r_ir_valid <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_ir_valid <= 1'b0;
            r_misalign <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (fetch_start && w_misal) begin
                        r_misalign <= 1'b1;
                    end else if (fetch_start) begin
                        r_state <= S_REQ;
                        r_req   <= 1'b1;
                        r_addr  <= w_faddr;
                    end
                end
                S_REQ: begin
                    if (imem_gnt) begin
                        r_req <= 1'b0;
                        if (imem_rvalid) begin
                            r_ir       <= imem_rdata;
                            r_ir_valid <= 1'b1;
                            r_state    <= S_IDLE;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        r_ir       <= imem_rdata;
                        r_ir_valid <= 1'b1;
                        r_state    <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req  = r_req;
    assign imem_addr = r_addr;
    assign pc        = w_pc;
    assign ir        = r_ir;
    assign ir_valid  = r_ir_valid;
    assign busy      = w_busy;
    assign misalign  = r_misalign;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: handshake timing, pending PC writes,
// misalignment and mid-transaction reset.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] npc;
    logic        pc_wr;
    logic        fetch_start;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] ir;
    logic        ir_valid;
    logic        busy;
    logic        misalign;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .npc         (npc),
        .pc_wr       (pc_wr),
        .fetch_start (fetch_start),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .pc          (pc),
        .ir          (ir),
        .ir_valid    (ir_valid),
        .busy        (busy),
        .misalign    (misalign)
    );

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        pc_wr       = 1'b0;
        fetch_start = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        npc        = 32'h0;
        imem_rdata = 32'h0;
        idle_in();
        tick();
        chk("rst_pc", pc, 32'h3000);
        chk("rst_ir", ir, 32'h0);
        chk("rst_irv", {31'b0, ir_valid}, 32'h0);
        chk("rst_req", {31'b0, imem_req}, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_mis", {31'b0, misalign}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        rst_n = 1'b1;
        tick();

        // basic fetch: gnt next cycle, rvalid one later
        fetch_start = 1'b1;
        tick();
        chk("f1_req", {31'b0, imem_req}, 32'h1);
        chk("f1_addr", imem_addr, 32'h3000);
        chk("f1_busy", {31'b0, busy}, 32'h1);
        fetch_start = 1'b0;
        imem_gnt    = 1'b1;
        tick();
        chk("f1_req_drop", {31'b0, imem_req}, 32'h0);
        chk("f1_wait_busy", {31'b0, busy}, 32'h1);
        chk("f1_no_irv", {31'b0, ir_valid}, 32'h0);
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h2408_000A;
        tick();
        chk("f1_ir", ir, 32'h2408_000A);
        chk("f1_irv", {31'b0, ir_valid}, 32'h1);
        chk("f1_idle", {31'b0, busy}, 32'h0);
        imem_rvalid = 1'b0;
        tick();
        chk("f1_irv_pulse", {31'b0, ir_valid}, 32'h0);
        chk("f1_ir_hold", ir, 32'h2408_000A);

        // pc_wr + fetch_start together, minimum latency
        pc_wr       = 1'b1;
        npc         = 32'h3010;
        fetch_start = 1'b1;
        tick();
        chk("f2_addr", imem_addr, 32'h3010);
        chk("f2_pc", pc, 32'h3010);
        idle_in();
        imem_gnt    = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0000_0020;
        tick();
        chk("f2_ir", ir, 32'h0000_0020);
        chk("f2_irv", {31'b0, ir_valid}, 32'h1);
        idle_in();

        // pending writes during WAIT; last one wins
        pc_wr = 1'b1;
        npc   = 32'h3000;
        tick();
        chk("f3_pc0", pc, 32'h3000);
        pc_wr       = 1'b0;
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        imem_gnt    = 1'b1;
        tick();
        imem_gnt = 1'b0;
        pc_wr    = 1'b1;
        npc      = 32'h3020;
        tick();
        chk("f3_pc_a", pc, 32'h3000);
        npc = 32'h3040;
        tick();
        chk("f3_pc_b", pc, 32'h3000);
        pc_wr       = 1'b0;
        fetch_start = 1'b1;
        tick();
        chk("f3_pc_c", pc, 32'h3000);
        chk("f3_ign_start", {31'b0, imem_req}, 32'h0);
        fetch_start = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h8C09_0004;
        tick();
        chk("f3_ir", ir, 32'h8C09_0004);
        chk("f3_pc_final", pc, 32'h3040);
        chk("f3_idle", {31'b0, busy}, 32'h0);
        idle_in();
        tick();

        // misaligned fetch address
        pc_wr       = 1'b1;
        npc         = 32'h3002;
        fetch_start = 1'b1;
        tick();
        chk("f4_mis", {31'b0, misalign}, 32'h1);
        chk("f4_req", {31'b0, imem_req}, 32'h0);
        chk("f4_busy", {31'b0, busy}, 32'h0);
        idle_in();
        tick();
        chk("f4_mis_pulse", {31'b0, misalign}, 32'h0);
        chk("f4_req2", {31'b0, imem_req}, 32'h0);

        // gnt held off for 5 cycles, then gnt+rvalid together
        pc_wr       = 1'b1;
        npc         = 32'h3100;
        fetch_start = 1'b1;
        tick();
        idle_in();
        for (int i = 0; i < 5; i++) begin
            chk("f5_req_hold", {31'b0, imem_req}, 32'h1);
            chk("f5_addr_hold", imem_addr, 32'h3100);
            tick();
        end
        imem_gnt    = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h1234_5678;
        tick();
        chk("f5_ir", ir, 32'h1234_5678);
        chk("f5_irv", {31'b0, ir_valid}, 32'h1);
        chk("f5_idle", {31'b0, busy}, 32'h0);
        chk("f5_req_off", {31'b0, imem_req}, 32'h0);
        imem_gnt   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        chk("f5_idle_rv", {31'b0, ir_valid}, 32'h0);
        chk("f5_ir_keep", ir, 32'h1234_5678);
        idle_in();

        // reset asserted during WAIT, late response afterwards
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        imem_gnt    = 1'b1;
        tick();
        imem_gnt = 1'b0;
        chk("f6_in_wait", {31'b0, busy}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("f6_async_busy", {31'b0, busy}, 32'h0);
        chk("f6_async_pc", pc, 32'h3000);
        tick();
        #2 rst_n = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hCAFE_F00D;
        tick();
        chk("f6_ir", ir, 32'h0);
        chk("f6_irv", {31'b0, ir_valid}, 32'h0);
        chk("f6_pc", pc, 32'h3000);
        idle_in();
        tick();
        chk("f6_irv2", {31'b0, ir_valid}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, SHALL be the PC value loaded on reset.
REQ-002 Parameter ADDR_W, default 32, SHALL be the PC and instruction-memory address width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 npc  input  32  SHALL carry the next-PC value from next-PC logic.
REQ-006 pc_wr  input  1  SHALL be the controller strobe that commits npc into pc.
REQ-007 fetch_start  input  1  SHALL be the controller request to fetch the instruction at pc.
REQ-008 imem_req  output  1  SHALL be the memory read request, held until granted.
REQ-009 imem_addr  output  32  SHALL be the read address, valid while imem_req=1.
REQ-010 imem_gnt  input  1  SHALL be the memory acceptance of the request.
REQ-011 imem_rvalid  input  1  SHALL qualify imem_rdata.
REQ-012 imem_rdata  input  32  SHALL carry the returned instruction word.
REQ-013 pc  output  32  SHALL be the architectural program counter.
REQ-014 ir  output  32  SHALL be the instruction register.
REQ-015 ir_valid  output  1  SHALL pulse high for 1 cycle when ir is updated.
REQ-016 busy  output  1  SHALL be high in any state other than IDLE.
REQ-017 misalign  output  1  SHALL pulse high for 1 cycle on a rejected misaligned fetch.

Function
REQ-018 The FSM SHALL have the states IDLE, REQ and WAIT.
REQ-019 IDLE, with fetch_start=1 and an aligned fetch address, SHALL go to REQ the next cycle with imem_req=1 and imem_addr=fetch address.
REQ-020 Fetch address SHALL be npc when pc_wr and fetch_start are both high in IDLE, else pc.
REQ-021 REQ SHALL hold imem_req and imem_addr stable until imem_gnt=1, then go to WAIT with imem_req=0.
REQ-022 In REQ, imem_gnt and imem_rvalid high in the same cycle SHALL load ir, pulse ir_valid and return directly to IDLE.
REQ-023 WAIT with imem_rvalid=1 SHALL load ir<=imem_rdata, pulse ir_valid the next cycle and return to IDLE.
REQ-024 Latency SHALL be at minimum 2 cycles from fetch_start to ir_valid when memory responds immediately.
REQ-025 In IDLE, pc_wr SHALL update pc<=npc the next cycle.
REQ-026 In REQ or WAIT, pc_wr SHALL latch npc into a pending register, and pc SHALL stay unchanged.
REQ-027 Multiple pc_wr strobes while busy SHALL leave only the last npc pending.
REQ-028 Any pending value SHALL be applied to pc in the same cycle the FSM returns to IDLE.
REQ-029 fetch_start while busy SHALL be ignored; no queuing.
REQ-030 A fetch address with bits [1:0]≠0 SHALL issue no request, pulse misalign for 1 cycle and remain in IDLE.
REQ-031 imem_rvalid or imem_gnt in IDLE SHALL be ignored.
REQ-032 ir SHALL hold its value between completions.

Reset
REQ-033 Reset SHALL force pc=RESET_PC, ir=0, ir_valid=0, imem_req=0, imem_addr=0, misalign=0 and busy=0, clear the pending register, and put the FSM in IDLE.
REQ-034 Reset asserted mid-transaction SHALL abort it, with no ir update from a late response after release.

Structure
REQ-035 The FSM state enum, the RESET_PC default and the width constants SHALL live in shared package mips_pkg.
REQ-036 The pc register plus pending-write logic SHALL be one sub-module, pc_reg; the FSM SHALL stay in fetch_unit.

Verification
REQ-037 Reset, fetch_start at pc=0x3000, gnt in the next cycle, rvalid one cycle later with 0x2408000A -> ir=0x2408000A, one ir_valid pulse, imem_addr=0x3000.
REQ-038 pc_wr with npc=0x3010 and fetch_start in the same IDLE cycle -> imem_addr=0x3010, and pc=0x3010 the next cycle.
REQ-039 pc_wr with 0x3020 then 0x3040 during WAIT -> pc stays 0x3000 until completion, then becomes 0x3040.
REQ-040 npc=0x3002 with pc_wr and fetch_start -> misalign pulse, imem_req stays 0.
REQ-041 gnt held low for 5 cycles -> imem_req and imem_addr stable throughout; gnt and rvalid in the same cycle -> completion and IDLE the next cycle.
REQ-042 rst_n low during WAIT, then rvalid after release -> pc=0x3000, ir=0, no ir_valid.
